// File: rtl/mem_pkg.sv
// Shared constants for the two-master memory arbiter: FSM state codes,
// master IDs and the default bus width.
package mem_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [0:0] M_CPU = 1'b0;
  localparam logic [0:0] M_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Master-side command/response signals plus the single-port memory bus.
// The arbiter uses the slave modport; requesters and memory sit on master.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             req0;
  logic             req1;
  logic             we0;
  logic             we1;
  logic [WIDTH-1:0] adr0;
  logic [WIDTH-1:0] adr1;
  logic [WIDTH-1:0] wd0;
  logic [WIDTH-1:0] wd1;
  logic             gnt0;
  logic             gnt1;
  logic             rvalid0;
  logic             rvalid1;
  logic [WIDTH-1:0] rdata;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wd0, wd1, memdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, memwrite, adr, writedata
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wd0, wd1, memdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, memwrite, adr, writedata
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master that did
// not win last time is chosen.
module rr_pick2
  import mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  // winner selection from current requests and previous winner
  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = M_LDR;
    end else begin
      winner = M_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory. One word
// access every two cycles; read data returns through a registered strobe.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  logic [0:0]       state_r;
  logic             last_r;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             rvalid0_r;
  logic             rvalid1_r;
  logic             memwrite_r;
  logic [WIDTH-1:0] adr_r;
  logic [WIDTH-1:0] wd_r;
  logic [WIDTH-1:0] rdata_r;

  logic             pick_s;
  logic             any_s;
  logic             we_sel_s;
  logic [WIDTH-1:0] adr_sel_s;
  logic [WIDTH-1:0] wd_sel_s;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last_r),
    .winner (pick_s),
    .any    (any_s)
  );

  // command of the master chosen this cycle
  always_comb begin
    if (pick_s == M_LDR) begin
      we_sel_s  = bus.we1;
      adr_sel_s = bus.adr1;
      wd_sel_s  = bus.wd1;
    end else begin
      we_sel_s  = bus.we0;
      adr_sel_s = bus.adr0;
      wd_sel_s  = bus.wd0;
    end
  end

  // FSM; the bus registers double as the latched command during ACCESS
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_r     <= M_LDR;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      rvalid0_r  <= 1'b0;
      rvalid1_r  <= 1'b0;
      memwrite_r <= 1'b0;
      adr_r      <= {WIDTH{1'b0}};
      wd_r       <= {WIDTH{1'b0}};
      rdata_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          rvalid0_r <= 1'b0;
          rvalid1_r <= 1'b0;
          if (any_s) begin
            state_r    <= ST_ACCESS;
            last_r     <= pick_s;
            gnt0_r     <= (pick_s == M_CPU);
            gnt1_r     <= (pick_s == M_LDR);
            memwrite_r <= we_sel_s;
            adr_r      <= adr_sel_s;
            wd_r       <= wd_sel_s;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r    <= ST_IDLE;
          gnt0_r     <= 1'b0;
          gnt1_r     <= 1'b0;
          memwrite_r <= 1'b0;
          adr_r      <= {WIDTH{1'b0}};
          wd_r       <= {WIDTH{1'b0}};
          // during ACCESS last_r already names the winner
          if (!memwrite_r) begin
            rdata_r   <= bus.memdata;
            rvalid0_r <= (last_r == M_CPU);
            rvalid1_r <= (last_r == M_LDR);
          end else begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt0_r     <= 1'b0;
          gnt1_r     <= 1'b0;
          rvalid0_r  <= 1'b0;
          rvalid1_r  <= 1'b0;
          memwrite_r <= 1'b0;
          adr_r      <= {WIDTH{1'b0}};
          wd_r       <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.rvalid0   = rvalid0_r;
  assign bus.rvalid1   = rvalid1_r;
  assign bus.rdata     = rdata_r;
  assign bus.memwrite  = memwrite_r;
  assign bus.adr       = adr_r;
  assign bus.writedata = wd_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(32)) bus ();
  mem_arbiter #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  // environment memory: combinational read, write on the rising edge
  logic [31:0] env_mem [0:255];
  assign bus.memdata = env_mem[bus.adr[7:0]];
  always @(posedge clk) begin
    if (bus.memwrite === 1'b1) env_mem[bus.adr[7:0]] <= bus.writedata;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference model: one pending access record plus its own memory image
  logic [31:0] m_mem [0:255];
  bit          started = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_id    = 1'b0;
  bit          m_we    = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_rv0   = 1'b0;
  bit          m_rv1   = 1'b0;
  logic [31:0] m_a     = 32'd0;
  logic [31:0] m_d     = 32'd0;
  logic [31:0] m_rdata = 32'd0;

  task automatic model_step();
    started = 1'b1;
    if (m_busy && m_we) m_mem[m_a[7:0]] = m_d;
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    if (reset) begin
      m_busy  = 1'b0;
      m_last  = 1'b1;
      m_rdata = 32'd0;
    end else if (m_busy) begin
      if (!m_we) begin
        m_rdata = m_mem[m_a[7:0]];
        m_rv0   = !m_id;
        m_rv1   = m_id;
      end
      m_busy = 1'b0;
    end else if (bus.req0 || bus.req1) begin
      m_id   = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      m_we   = m_id ? bus.we1  : bus.we0;
      m_a    = m_id ? bus.adr1 : bus.adr0;
      m_d    = m_id ? bus.wd1  : bus.wd0;
      m_busy = 1'b1;
      m_last = m_id;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // every-cycle comparison of all outputs against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("gnt0",      {31'd0, bus.gnt0},     {31'd0, m_busy && !m_id});
      chk("gnt1",      {31'd0, bus.gnt1},     {31'd0, m_busy && m_id});
      chk("rvalid0",   {31'd0, bus.rvalid0},  {31'd0, m_rv0});
      chk("rvalid1",   {31'd0, bus.rvalid1},  {31'd0, m_rv1});
      chk("rdata",     bus.rdata,             m_rdata);
      chk("memwrite",  {31'd0, bus.memwrite}, {31'd0, m_busy && m_we});
      chk("adr",       bus.adr,               m_busy ? m_a : 32'd0);
      chk("writedata", bus.writedata,         m_busy ? m_d : 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (id) begin
      bus.req1 = r; bus.we1 = w; bus.adr1 = a; bus.wd1 = d;
    end else begin
      bus.req0 = r; bus.we0 = w; bus.adr0 = a; bus.wd0 = d;
    end
  endtask

  task automatic wait_gnt(input bit id, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      cyc();
      seen = id ? (bus.gnt1 === 1'b1) : (bus.gnt0 === 1'b1);
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int q[$];
    int exp_seq[4];
    bit act0, act1;
    int w0, w1;

    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'(i * 5 + 3);
      m_mem[i]   = 32'(i * 5 + 3);
    end
    env_mem[4] = 32'd7;
    m_mem[4]   = 32'd7;

    // reset with both requests high
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd2, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_gnt",    {31'd0, bus.gnt0 | bus.gnt1}, 32'd0);
      chk("rst_rvalid", {31'd0, bus.rvalid0 | bus.rvalid1}, 32'd0);
      chk("rst_bus",    bus.adr | bus.writedata | {31'd0, bus.memwrite}, 32'd0);
      chk("rst_rdata",  bus.rdata, 32'd0);
    end
    reset = 1'b0;
    cyc();
    chk("first_tie_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("first_tie_gnt1", {31'd0, bus.gnt1}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("first_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("first_rdata",   bus.rdata, 32'd8);

    // master 1 writes 210 to 255, then reads it back
    drive(1'b1, 1'b1, 1'b1, 32'd255, 32'd210);
    wait_gnt(1'b1, "wr_gnt1");
    chk("wr_memwrite",  {31'd0, bus.memwrite}, 32'd1);
    chk("wr_adr",       bus.adr, 32'd255);
    chk("wr_writedata", bus.writedata, 32'd210);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("wr_one_cycle", {31'd0, bus.memwrite}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd255, 32'd0);
    wait_gnt(1'b1, "rd_gnt1");
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("rd_rvalid1", {31'd0, bus.rvalid1}, 32'd1);
    chk("rd_rdata",   bus.rdata, 32'd210);

    // contention for 8 cycles
    drive(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd20, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("cont_no_dual", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
      if (bus.gnt0 === 1'b1) q.push_back(0);
      if (bus.gnt1 === 1'b1) q.push_back(1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_seq = '{0, 1, 0, 1};
    chk("cont_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_seq", (i < q.size()) ? 32'(q[i]) : 32'hdead, 32'(exp_seq[i]));
    end

    // address change during ACCESS must not reach the bus
    drive(1'b0, 1'b1, 1'b0, 32'd12, 32'd0);
    wait_gnt(1'b0, "hold_gnt0");
    drive(1'b0, 1'b1, 1'b0, 32'd77, 32'd0);
    #3;
    chk("hold_adr", bus.adr, 32'd12);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("hold_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    chk("hold_rdata",   bus.rdata, 32'd63);

    // reset during a master 0 read, master 1 pending
    drive(1'b0, 1'b1, 1'b0, 32'd16, 32'd0);
    wait_gnt(1'b0, "rm_gnt0");
    drive(1'b1, 1'b1, 1'b0, 32'd20, 32'd0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("rm_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
    chk("rm_rdata",   bus.rdata, 32'd0);
    reset = 1'b0;
    cyc();
    chk("rm_gnt1", {31'd0, bus.gnt1}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("rm_rvalid1", {31'd0, bus.rvalid1}, 32'd1);
    chk("rm_rdata1",  bus.rdata, 32'd103);

    // a write leaves rdata alone
    drive(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
    wait_gnt(1'b0, "wk_rd_gnt0");
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("wk_rd_rdata", bus.rdata, 32'd7);
    drive(1'b0, 1'b1, 1'b1, 32'd8, 32'd99);
    wait_gnt(1'b0, "wk_wr_gnt0");
    chk("wk_wr_memwrite", {31'd0, bus.memwrite}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("wk_no_rvalid", {31'd0, bus.rvalid0 | bus.rvalid1}, 32'd0);
    chk("wk_rdata_kept", bus.rdata, 32'd7);

    // randomized traffic obeying the master handshake
    act0 = 1'b0; act1 = 1'b0; w0 = 0; w1 = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (reset) begin
        w0 = 0; w1 = 0;
      end else begin
        if (act0) w0++;
        if (act1) w1++;
      end
      chk("lat0", {31'd0, act0 && (bus.gnt0 !== 1'b1) && (w0 >= 3)}, 32'd0);
      chk("lat1", {31'd0, act1 && (bus.gnt1 !== 1'b1) && (w1 >= 3)}, 32'd0);
      if (act0 && bus.gnt0 === 1'b1) begin
        bus.req0 = 1'b0; act0 = 1'b0;
      end else if (!act0 && $urandom_range(0, 2) == 0) begin
        drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
        act0 = 1'b1; w0 = 0;
      end
      if (act1 && bus.gnt1 === 1'b1) begin
        bus.req1 = 1'b0; act1 = 1'b0;
      end else if (!act1 && $urandom_range(0, 2) == 0) begin
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
        act1 = 1'b1; w1 = 0;
      end
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-port external memory (`exmemory`, combinational read, write on clock edge) between the MIPS core's memory port and a second requester: a program loader or DMA engine. It sits between the masters and the memory in `top`. It grants one word access at a time using round-robin priority and returns read data through a registered valid strobe. Write acknowledgement is the grant itself.

## Interface
- `WIDTH`, 32, data and address width
- `clk` in 1: system clock, all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `req0` / `req1` in 1: access request, master 0 (CPU) / master 1 (loader)
- `we0` / `we1` in 1: 1 = write, 0 = read; held with req
- `adr0` / `adr1` in WIDTH: word address; held with req
- `wd0` / `wd1` in WIDTH: write data; held with req
- `gnt0` / `gnt1` out 1: one-cycle pulse, the master's access is on the memory bus this cycle
- `rvalid0` / `rvalid1` out 1: one-cycle pulse, `rdata` holds this master's read result
- `rdata` out WIDTH: registered read data, shared by both masters
- `memwrite` out 1: memory write enable
- `adr` out WIDTH: memory address
- `writedata` out WIDTH: memory write data
- `memdata` in WIDTH: memory read data, combinational from `adr`

## Operation
- FSM with two states.
  - IDLE: sample `req0`/`req1`. If any request is high, latch the winner's `we`/`adr`/`wd` and winner ID, then go to ACCESS.
  - ACCESS: memory bus carries the latched command and `gnt<winner>`=1. Then go to IDLE unconditionally.
- Round-robin: `last` holds the ID of the most recent winner.
  - Only one request high: that master wins.
  - Both high: the master ≠ `last` wins.
  - `last` updates on every IDLE→ACCESS transition.
- Memory bus in IDLE: `memwrite`=0, `adr`=0, `writedata`=0.
- Memory bus in ACCESS: `memwrite`=latched `we`, `adr`=latched address, `writedata`=latched data.
- Read in ACCESS: `memdata` is captured into `rdata` at the closing edge. `rvalid<winner>`=1 for the following cycle (IDLE).
- `rdata` holds its value until the next read capture. Writes never change `rdata`.
- Master obligations:
  - hold `req`/`we`/`adr`/`wd` stable from assertion until `gnt` is seen;
  - deassert `req` at the edge ending the `gnt` cycle.
- A request still high in the IDLE after its grant is treated as a new request.
- Command inputs are ignored outside IDLE sampling. Changes during ACCESS have no effect on the bus.
- Reset (any state, including mid-ACCESS) forces:
  - state IDLE, `last`=1 (master 0 wins the first tie);
  - all `gnt`/`rvalid` 0, `rdata` 0, `memwrite` 0, `adr` 0, `writedata` 0.
- A read interrupted by reset produces no `rvalid`.

## Timing
- Request sampled at edge E (state IDLE). ACCESS and `gnt` occupy cycle E..E+1. `rvalid` occupies cycle E+1..E+2, which is the next IDLE.
- Latency from `req` high to `gnt`: 1 cycle if uncontended. Worst case is 3 cycles, when the other master's access is in progress.
- Peak throughput: one access per 2 cycles. With both masters continuously requesting, grants strictly alternate.
- `rvalid` of access N coincides with IDLE sampling for access N+1. Both may be active in the same cycle.
- All outputs are registered or decoded from state and latched command only. There is no combinational path from `req*`/`adr*` to memory-side outputs.
- `memwrite` is high for exactly one cycle per write.

## Structure
- Shared package `mem_pkg`:
  - state encoding constants `ST_IDLE`/`ST_ACCESS`;
  - master ID constants `M_CPU`=0, `M_LDR`=1.
- Single module. An optional sub-module `rr_pick2` (combinational round-robin picker: req0, req1, last → winner, any) is natural and is reused by future N-master versions.
- Integration: in `top`, `mips` connects as master 0 and `exmemory` hangs off the memory-side ports.

## Test plan
- Reset check: assert `reset` for 2 cycles with both `req` high → all outputs 0 during reset. The first grant after release goes to master 0 (tie, `last`=1).
- Single write then read:
  - master 1 writes 210 to address 255 → `memwrite`=1, `adr`=255, `writedata`=210 for exactly 1 cycle, with `gnt1`.
  - master 1 then reads address 255 → `rvalid1` one cycle after `gnt1`, `rdata`=210.
- Contention: both masters hold `req` for 8 cycles with distinct addresses → grants alternate 0,1,0,1. There are no back-to-back grants to the same master and no cycle with `gnt0`&`gnt1`.
- Hold check: master 0 changes `adr0` during its ACCESS cycle → memory bus still shows the address latched in IDLE.
- Reset mid-operation: assert `reset` during ACCESS of a master 0 read → no `rvalid0` follows, and `rdata` is 0. After release, a pending `req1` is granted 1 cycle later.
- Write does not disturb `rdata`: read address 4 (value 7), then write 99 to address 8 → `rdata` remains 7 and no `rvalid` is produced for the write.
